// File: rtl/filter_pkg.sv
// filter_pkg: types and defaults shared by the window generator and the kernel
// filters that consume its 3x3 windows.
package filter_pkg;

  localparam int DATA_SIZE_DEF   = 8;
  localparam int KERNEL_SIZE_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } wg_state_e;

  // Window as seen by the kernel: [row][col][bit], row 0 = top, col 0 = left.
  typedef logic [KERNEL_SIZE_DEF-1:0][KERNEL_SIZE_DEF-1:0][DATA_SIZE_DEF-1:0] window_t;

endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel stream in, window stream out.
// Optional frame counter signal follows macro WINDOW_GEN_FRAME_CNT_EN.
interface window_gen_if
  import filter_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
);
  logic                                                  valid;
  logic [DATA_SIZE-1:0]                                  data;
  logic                                                  ready;
  logic                                                  win_valid;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] win;
  logic                                                  eof;
`ifdef WINDOW_GEN_FRAME_CNT_EN
  logic [15:0]                                           frame_cnt;

  modport master (output valid, data, input ready, win_valid, win, eof, frame_cnt);
  modport slave  (input valid, data, output ready, win_valid, win, eof, frame_cnt);
`else
  modport master (output valid, data, input ready, win_valid, win, eof);
  modport slave  (input valid, data, output ready, win_valid, win, eof);
`endif
endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row. On a write the old entry at the same address is
// visible on rdata_o in that cycle, so it can be passed down the chain.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Row storage; contents are never cleared, stale rows are never read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/window_gen.sv
// window_gen: turns a raster pixel stream into 3x3 sliding windows.
// Optional: define WINDOW_GEN_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module window_gen
  import filter_pkg::*;
#(
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 256
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_rst,
  input  logic                                                  i_valid,
  input  logic [DATA_SIZE-1:0]                                  i_data,
  output logic                                                  o_ready,
  output logic                                                  o_valid,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] o_data,
  output logic                                                  o_eof
`ifdef WINDOW_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]                                           o_frame_cnt
`endif
);
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int NLB = KERNEL_SIZE - 1;

  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] win_t;

  wg_state_e                                        state_q, state_d;
  logic [CW-1:0]                                    col_q, col_d;
  logic [RW-1:0]                                    row_q, row_d;
  logic                                             ready_q, valid_q, eof_q;
  win_t                                             data_q, win_d;
  logic [KERNEL_SIZE-1:0][NLB-1:0][DATA_SIZE-1:0]   sr_q;     // two most recent columns
  logic [NLB-1:0][DATA_SIZE-1:0]                    lb_rdata; // [0] = row y-1, [1] = row y-2
  logic [KERNEL_SIZE-1:0][DATA_SIZE-1:0]            col_new;  // incoming column, top first
  logic                                             accept, last_px, fill_end, emit;

  assign accept   = i_valid & ready_q;
  assign last_px  = (row_q == RW'(IMG_HEIGHT-1)) && (col_q == CW'(IMG_WIDTH-1));
  assign fill_end = (row_q == RW'(2)) && (col_q == CW'(2));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Line buffer chain: the pixel enters buffer 0, the displaced row y-1 pixel
  // moves into buffer 1 and becomes row y-2 for the next row.
  for (genvar i = 0; i < NLB; i++) begin : g_lb
    logic [DATA_SIZE-1:0] wdata;
    if (i == 0) begin : g_head
      assign wdata = i_data;
    end else begin : g_chain
      assign wdata = lb_rdata[i-1];
    end
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_SIZE), .AW(CW)) u_lb (
      .clk_i   (i_clk),
      .we_i    (accept),
      .addr_i  (col_q),
      .wdata_i (wdata),
      .rdata_o (lb_rdata[i])
    );
  end

  assign col_new[NLB] = i_data;
  for (genvar i = 0; i < NLB; i++) begin : g_col
    assign col_new[i] = lb_rdata[NLB-1-i];
  end

  // Window after this pixel: stored columns on the left, new column on the right.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < NLB; c++) win_d[r][c] = sr_q[r][c];
      win_d[r][NLB] = col_new[r];
    end
  end

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_FILL;
      S_FILL: begin
        if (accept && last_px)       state_d = S_DONE;
        else if (accept && fill_end) state_d = S_RUN;
      end
      S_RUN:  if (accept && last_px) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared when the frame completes.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (state_d == S_DONE) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == CW'(IMG_WIDTH-1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= (state_d != S_DONE);
      valid_q <= emit;
      eof_q   <= emit && last_px;
      if (emit) data_q <= win_d;
    end
  end

  // Column shift register; only read once two fresh columns of the row exist.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < NLB; c++) sr_q[r][c] <= win_d[r][c+1];
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_eof   = eof_q;
  assign o_data  = data_q;

`ifdef WINDOW_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed frames, bumped in the DONE cycle, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  frame_cnt_q <= '0;
    else if (state_q == S_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed frames plus random traffic against an image model.
module tb_window_gen;
  import filter_pkg::*;

  localparam int W = 4, H = 4, NPIX = W*H;
  localparam int WB = 5, HB = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  window_gen_if bus_a ();
  window_gen_if bus_b ();

  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_valid(bus_a.valid), .i_data(bus_a.data),
    .o_ready(bus_a.ready), .o_valid(bus_a.win_valid), .o_data(bus_a.win), .o_eof(bus_a.eof)
`ifdef WINDOW_GEN_FRAME_CNT_EN
    , .o_frame_cnt(bus_a.frame_cnt)
`endif
  );

  window_gen #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_valid(bus_b.valid), .i_data(bus_b.data),
    .o_ready(bus_b.ready), .o_valid(bus_b.win_valid), .o_data(bus_b.win), .o_eof(bus_b.eof)
`ifdef WINDOW_GEN_FRAME_CNT_EN
    , .o_frame_cnt(bus_b.frame_cnt)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: image stored by raster index, window read straight out of it.
  logic [7:0] img [H][W];
  int         k;
  bit         armed = 0, in_done = 0;
  logic       exp_valid = 0, exp_eof = 0, exp_ready = 0;
  window_t    exp_win = '0;
  int         fcnt_exp = 0;
  window_t    obs_q[$];
  bit         obs_eof_q[$];
  int         ready_low = 0;

  function automatic window_t mk_win(input int base);
    window_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'(base + r*W + c);
    return w;
  endfunction

  // One cycle: check what the last edge produced, drive the next inputs, predict.
  task automatic step(input bit v, input logic [7:0] d, input bit rst, output bit acc);
    bit last;
    int y, x;
    @(negedge clk);
    if (armed) begin
      chk("o_valid", bus_a.win_valid, exp_valid);
      chk("o_eof",   bus_a.eof, exp_eof);
      chk("o_ready", bus_a.ready, exp_ready);
      chk("o_data",  bus_a.win, exp_win);
`ifdef WINDOW_GEN_FRAME_CNT_EN
      chk("o_frame_cnt", bus_a.frame_cnt, 16'(fcnt_exp));
`endif
      if (bus_a.win_valid === 1'b1) begin
        obs_q.push_back(bus_a.win);
        obs_eof_q.push_back(bus_a.eof);
      end
      if (bus_a.ready !== 1'b1) ready_low++;
    end
    bus_a.valid = v;
    bus_a.data  = d;
    rst_a       = rst;
    acc  = 0;
    last = 0;
    if (rst) begin
      armed = 1; k = 0; in_done = 0; fcnt_exp = 0;
      exp_valid = 0; exp_eof = 0; exp_ready = 0; exp_win = '0;
    end else begin
      if (in_done) fcnt_exp = (fcnt_exp + 1) % 65536;
      acc = v && exp_ready;
      exp_valid = 0;
      exp_eof   = 0;
      if (acc) begin
        y = k / W;
        x = k % W;
        img[y][x] = d;
        last = (k == NPIX-1);
        if (y >= 2 && x >= 2) begin
          exp_valid = 1;
          exp_eof   = last;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) exp_win[r][c] = img[y-2+r][x-2+c];
        end
        k = last ? 0 : k + 1;
      end
      exp_ready = !last;
      in_done   = last;
    end
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    bit acc;
    int n = 0;
    repeat (gap) step(1'b0, 8'($urandom), 1'b0, acc);
    do begin
      step(1'b1, d, 1'b0, acc);
      n++;
    end while (!acc && n < 8);
    chk("accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic check_frame(input string tag, input int idx0, input int base);
    if (obs_q.size() >= idx0 + 4) begin
      chk({tag, "_first"},     obs_q[idx0], mk_win(base));
      chk({tag, "_first_eof"}, obs_eof_q[idx0], 1'b0);
      chk({tag, "_last"},      obs_q[idx0+3], mk_win(base + W + 1));
      chk({tag, "_last_eof"},  obs_eof_q[idx0+3], 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0t", $time);
    $fatal(1);
  end

  initial begin
    bit acc;
    int nb, sent;
    bus_a.valid = 0; bus_a.data = 0; rst_a = 1;
    bus_b.valid = 0; bus_b.data = 0; rst_b = 1;

    repeat (2) step(1'b0, 8'h00, 1'b1, acc);

    // Basic frame, back-to-back pixels.
    obs_q.delete(); obs_eof_q.delete();
    for (int i = 0; i < NPIX; i++) send(8'(i), 0);
    idle(3);
    chk("basic_count", obs_q.size(), 4);
    check_frame("basic", 0, 0);
`ifdef WINDOW_GEN_FRAME_CNT_EN
    chk("fcnt_1", bus_a.frame_cnt, 16'd1);
`endif

    // Same frame with two idle cycles before every pixel.
    obs_q.delete(); obs_eof_q.delete();
    for (int i = 0; i < NPIX; i++) send(8'(i), 2);
    idle(3);
    chk("gaps_count", obs_q.size(), 4);
    check_frame("gaps", 0, 0);
`ifdef WINDOW_GEN_FRAME_CNT_EN
    chk("fcnt_2", bus_a.frame_cnt, 16'd2);
`endif

    // Two frames with no gap: pixel 100 waits out the single DONE cycle.
    obs_q.delete(); obs_eof_q.delete();
    for (int i = 0; i < NPIX; i++) send(8'(i), 0);
    ready_low = 0;
    send(8'd100, 0);
    chk("b2b_ready_low", ready_low, 1);
`ifdef WINDOW_GEN_FRAME_CNT_EN
    chk("fcnt_3", bus_a.frame_cnt, 16'd3);
`endif
    for (int i = 1; i < NPIX; i++) send(8'(100 + i), 0);
    idle(3);
    chk("b2b_count", obs_q.size(), 8);
    check_frame("b2b_f1", 0, 0);
    check_frame("b2b_f2", 4, 100);

    // Reset after pixel 9, then a full frame.
    obs_q.delete(); obs_eof_q.delete();
    for (int i = 0; i < 10; i++) send(8'(i), 0);
    step(1'b0, 8'h00, 1'b1, acc);
    idle(1);
`ifdef WINDOW_GEN_FRAME_CNT_EN
    chk("fcnt_rst", bus_a.frame_cnt, 16'd0);
`endif
    for (int i = 0; i < 10; i++) send(8'(i), 0);
    chk("rst_no_early_win", obs_q.size(), 0);
    for (int i = 10; i < NPIX; i++) send(8'(i), 0);
    idle(3);
    chk("rst_count", obs_q.size(), 4);
    check_frame("rst", 0, 0);

    // Random pixels, random gaps, occasional resets; model checks every cycle.
    for (int p = 0; p < 160; p++) begin
      if ($urandom_range(0, 49) == 0) step(1'b0, 8'h00, 1'b1, acc);
      send(8'($urandom), int'($urandom_range(0, 2)));
    end
    idle(3);

    // Wide values on a 5x3 frame.
    repeat (2) @(negedge clk);
    rst_b = 0;
    nb = 0;
    sent = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (bus_b.win_valid === 1'b1) begin
        nb++;
        chk("wide_data", bus_b.win, {9{8'hFF}});
        chk("wide_eof", bus_b.eof, nb == 3);
      end else begin
        chk("wide_eof_idle", bus_b.eof, 1'b0);
      end
      if (sent < WB*HB && bus_b.ready === 1'b1) begin
        bus_b.valid = 1;
        bus_b.data  = 8'hFF;
        sent++;
      end else begin
        bus_b.valid = 0;
      end
    end
    chk("wide_count", nb, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, pixel width in bits.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, window edge; only 3 is supported.
REQ-003 SHALL have parameter IMG_WIDTH, default 8, pixels per row; legal range at least 3.
REQ-004 SHALL have parameter IMG_HEIGHT, default 256, rows per frame; legal range at least 3.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1 bit: an input pixel is present.
REQ-008 SHALL have port i_data, input, DATA_SIZE bits: pixel, raster order (row-major, top-left first).
REQ-009 SHALL have port o_ready, output, 1 bit: a pixel is accepted when i_valid and o_ready are both high.
REQ-010 SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a new window on o_data.
REQ-011 SHALL have port o_data, output, [DATA_SIZE-1:0] x [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]: 3x3 window for the downstream kernel filter.
REQ-012 SHALL have port o_eof, output, 1 bit: high together with o_valid on the last window of a frame.

Function
REQ-013 SHALL have row and column counters that advance only on accepted pixels; gaps in i_valid are legal and change no state.
REQ-014 SHALL have the FSM IDLE -> FILL -> RUN -> DONE -> IDLE:
- IDLE -> FILL on the first accepted pixel.
- FILL -> RUN when the accepted pixel is at row 2, col 2.
- RUN -> DONE when the accepted pixel is at row IMG_HEIGHT-1, col IMG_WIDTH-1.
- DONE -> IDLE after exactly 1 cycle.
REQ-015 SHALL keep two line buffers of IMG_WIDTH entries holding rows y-1 and y-2, plus a 3x3 shift register of columns.
REQ-016 SHALL, on accepting pixel (y,x) with y>=2 and x>=2, in the next cycle drive o_valid=1 with o_data[r][c] = pixel(y-2+r, x-2+c).
- Row 0 of the window is the oldest (top) row.
- Column 0 of the window is the leftmost column.
REQ-017 SHALL never produce windows for x<2 or y<2, and no window may mix pixels from different rows.
- Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-018 SHALL hold o_data at its last value while o_valid is low.
REQ-019 SHALL assert o_eof only in the same cycle as the final o_valid of the frame.
REQ-020 SHALL drive o_ready=1 in IDLE, FILL and RUN, and o_ready=0 in DONE.
- A pixel presented during DONE is not accepted; upstream holds it.
REQ-021 SHALL reset the counters to 0 on entering DONE, so the next accepted pixel is (0,0) of a new frame.
REQ-022 SHALL apply no backpressure from downstream; the consumer accepts every o_valid pulse.

Reset
REQ-023 SHALL, while i_rst=1 at a clock edge, set:
- state IDLE;
- counters 0;
- o_valid=0, o_eof=0, o_ready=0;
- o_data all zeros.
REQ-024 SHALL raise o_ready the first cycle after i_rst deasserts.
REQ-025 SHALL handle reset mid-frame: the partial frame is discarded, no further window from it is emitted, and line buffer contents need not be cleared.

Configuration
REQ-026 SHALL support macro WINDOW_GEN_FRAME_CNT_EN.
- When defined: output port o_frame_cnt, 16 bits, reset 0; increments in the DONE cycle and wraps 0xFFFF -> 0x0000.
- When undefined: port and counter are absent, and all other behaviour is identical.

Structure
REQ-027 SHALL place in shared package filter_pkg:
- the FSM state enum typedef;
- the window array typedef;
- default constants for DATA_SIZE and KERNEL_SIZE.
REQ-028 SHALL place one row memory in sub-module line_buffer (depth IMG_WIDTH, width DATA_SIZE, write-then-read-old on accept); it is instantiated twice.

Verification
REQ-029 SHALL cover basic frame: W=4, H=4, pixels 0..15 back-to-back.
- One cycle after pixel 10: o_valid=1, o_data={{0,1,2},{4,5,6},{8,9,10}}.
- Exactly 4 windows are produced.
- Last window is {{5,6,7},{9,10,11},{13,14,15}} with o_eof=1.
REQ-030 SHALL cover gaps: same frame with i_valid low 2 cycles between every pixel -> identical window sequence, each o_valid exactly 1 cycle after the completing pixel.
REQ-031 SHALL cover back-to-back frames: second frame pixels 100..115 presented immediately after pixel 15.
- o_ready=0 for exactly 1 cycle.
- Pixel 100 is accepted as (0,0).
- First window of frame 2 is {{100,101,102},{104,105,106},{108,109,110}}.
REQ-032 SHALL cover reset mid-frame: i_rst=1 for 1 cycle after pixel 9 of frame 1, then pixels 0..15 -> no window before the new pixel 10, then the same 4 windows as REQ-029.
REQ-033 SHALL cover wide values: W=5, H=3, all pixels 0xFF -> exactly 3 windows of all 0xFF, o_eof on the third.
REQ-034 SHALL cover the frame counter, with WINDOW_GEN_FRAME_CNT_EN defined: 3 frames of W=4, H=4 -> o_frame_cnt reads 1, 2, 3 after each DONE cycle, and 0 after i_rst.
